// File: rtl/unit_arbiter.sv
// unit_arbiter: shares one ALU and one MEM unit among N_THREADS threads,
// each unit class with its own independent round-robin arbiter.
//   clk, rst (async, active-low)
//   thr_sel[2*i +: 2]         thread i request: 0 none, 1 ALU, 2 MEM (3 = none)
//   thr_ctrl[i*WORD_W +: W]   thread i control word
//   thr_in[(2*i+j)*WORD_W]    thread i operand j
//   thr_done[i], thr_out[i]   one-cycle completion pulse and result (0 when not done)
//   alu_ctrl/alu_in/alu_out   shared ALU; operand j at alu_in[j*WORD_W +: WORD_W]
//   mem_ctrl/mem_in/mem_out   shared MEM; same operand packing
module unit_arbiter #(
    parameter int N_THREADS = 4,
    parameter int WORD_W    = 32,
    parameter int ALU_LAT   = 0,
    parameter int MEM_LAT   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2*N_THREADS-1:0]          thr_sel,
    input  logic [N_THREADS*WORD_W-1:0]     thr_ctrl,
    input  logic [2*N_THREADS*WORD_W-1:0]   thr_in,
    output logic [N_THREADS-1:0]            thr_done,
    output logic [N_THREADS*WORD_W-1:0]     thr_out,
    output logic [WORD_W-1:0]               alu_ctrl,
    output logic [2*WORD_W-1:0]             alu_in,
    input  logic [WORD_W-1:0]               alu_out,
    output logic [WORD_W-1:0]               mem_ctrl,
    output logic [2*WORD_W-1:0]             mem_in,
    input  logic [WORD_W-1:0]               mem_out
);
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    logic [N_THREADS-1:0] alu_req, mem_req, alu_done, mem_done;

    for (genvar i = 0; i < N_THREADS; i++) begin : g_thr
        assign alu_req[i] = thr_sel[2*i +: 2] == SEL_ALU;
        assign mem_req[i] = thr_sel[2*i +: 2] == SEL_MEM;
        // A thread requests one unit at a time, so at most one done source is live.
        assign thr_out[i*WORD_W +: WORD_W] = alu_done[i] ? alu_out : (mem_done[i] ? mem_out : '0);
    end

    assign thr_done = alu_done | mem_done;

    unit_arbiter_rr #(.N(N_THREADS), .W(WORD_W), .LAT(ALU_LAT)) u_alu (
        .clk       (clk),
        .rst       (rst),
        .req       (alu_req),
        .thr_ctrl  (thr_ctrl),
        .thr_in    (thr_in),
        .done      (alu_done),
        .unit_ctrl (alu_ctrl),
        .unit_in   (alu_in)
    );

    unit_arbiter_rr #(.N(N_THREADS), .W(WORD_W), .LAT(MEM_LAT)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .req       (mem_req),
        .thr_ctrl  (thr_ctrl),
        .thr_in    (thr_in),
        .done      (mem_done),
        .unit_ctrl (mem_ctrl),
        .unit_in   (mem_in)
    );
endmodule

// unit_arbiter_rr: round-robin arbiter and latency tracker for one shared unit.
//   req[i]      thread i wants this unit
//   done[i]     one-hot completion pulse for thread i
//   unit_ctrl   selected thread's control word (0 when idle or in reset)
//   unit_in     selected thread's two operands (0 when idle or in reset)
module unit_arbiter_rr #(
    parameter int N   = 4,
    parameter int W   = 32,
    parameter int LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*W-1:0]     thr_ctrl,
    input  logic [2*N*W-1:0]   thr_in,
    output logic [N-1:0]       done,
    output logic [W-1:0]       unit_ctrl,
    output logic [2*W-1:0]     unit_in
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(LAT + 1) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, win, src;
    logic [CW-1:0]   count_q, count_d;
    logic            found, drive;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (int'(p) == N - 1) ? '0 : p + PW'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin : scan
        int idx;
        found = 1'b0;
        win   = rr_ptr_q;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        done     = '0;
        drive    = 1'b0;
        src      = owner_q;
        if (state_q == BUSY) begin
            drive   = 1'b1;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                done[owner_q] = 1'b1;
                rr_ptr_d      = next_ptr(owner_q);
                state_d       = IDLE;
            end
        end else if (found) begin
            drive = 1'b1;
            src   = win;
            if (LAT == 0) begin
                done[win] = 1'b1;
                rr_ptr_d  = next_ptr(win);
            end else begin
                owner_d = win;
                count_d = CW'(LAT);
                state_d = BUSY;
            end
        end
        // Outputs are forced low for the whole reset window, not just after the edge.
        done = rst ? done : '0;
    end

    assign unit_ctrl = (drive && rst) ? thr_ctrl[int'(src)*W +: W] : '0;
    assign unit_in   = (drive && rst) ? thr_in[2*int'(src)*W +: 2*W] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_unit_arbiter.sv
// tb_unit_arbiter: scoreboard bench for unit_arbiter with MEM_LAT 1, 2 and 3 side by side.
module tb_unit_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int ND = 3;
    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_ALU  = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;

    typedef struct {
        int           thr;
        logic [W-1:0] val;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2*N-1:0]   thr_sel = '0;
    logic [N*W-1:0]   thr_ctrl = '0;
    logic [2*N*W-1:0] thr_in = '0;

    logic [N-1:0]     done_w [ND];
    logic [N*W-1:0]   out_w [ND];
    logic [W-1:0]     alu_ctrl_w [ND];
    logic [W-1:0]     alu_out_w [ND];
    logic [W-1:0]     mem_ctrl_w [ND];
    logic [W-1:0]     mem_out_w [ND];
    logic [2*W-1:0]   alu_in_w [ND];
    logic [2*W-1:0]   mem_in_w [ND];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ops_left [N];

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        return a + b + c;
    endfunction

    function automatic logic [W-1:0] mem_f(input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        return (a ^ 32'h5A5A_0000) + (b << 4) + c;
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        unit_arbiter #(.N_THREADS(N), .WORD_W(W), .ALU_LAT(0), .MEM_LAT(g + 1)) dut (
            .clk      (clk),
            .rst      (rst),
            .thr_sel  (thr_sel),
            .thr_ctrl (thr_ctrl),
            .thr_in   (thr_in),
            .thr_done (done_w[g]),
            .thr_out  (out_w[g]),
            .alu_ctrl (alu_ctrl_w[g]),
            .alu_in   (alu_in_w[g]),
            .alu_out  (alu_out_w[g]),
            .mem_ctrl (mem_ctrl_w[g]),
            .mem_in   (mem_in_w[g]),
            .mem_out  (mem_out_w[g])
        );
        assign alu_out_w[g] = alu_f(alu_ctrl_w[g], alu_in_w[g][W-1:0], alu_in_w[g][2*W-1:W]);
        assign mem_out_w[g] = mem_f(mem_ctrl_w[g], mem_in_w[g][W-1:0], mem_in_w[g][2*W-1:W]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_thr(input int i, input logic [1:0] s, input logic [W-1:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b, input int ops);
        thr_sel[2*i +: 2]         = s;
        thr_ctrl[i*W +: W]        = c;
        thr_in[2*i*W +: W]        = a;
        thr_in[(2*i+1)*W +: W]    = b;
        ops_left[i]               = ops;
    endtask

    task automatic push_exp(input int t, input logic [W-1:0] v, input int c);
        exp_t e;
        e.thr = t;
        e.val = v;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        thr_sel  = '0;
        thr_ctrl = '0;
        thr_in   = '0;
        foreach (ops_left[i]) ops_left[i] = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Steps n cycles on DUT d: each done is matched against the scoreboard,
    // and a thread withdraws its request once its last op completes.
    task automatic run(input int d, input int n);
        logic [N-1:0] drop;
        logic [W-1:0] o;
        int hit;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drop = '0;
            for (int i = 0; i < N; i++) begin
                o = out_w[d][i*W +: W];
                checks++;
                if (done_w[d][i]) begin
                    hit = -1;
                    foreach (sb[k]) if (hit < 0 && sb[k].thr == i) hit = k;
                    if (hit < 0) begin
                        errors++;
                        $display("FAIL unexpected_done dut%0d thr%0d: done at cyc %0d out %h, required no done", d, i, cyc, o);
                    end else begin
                        if (o !== sb[hit].val || cyc != sb[hit].cyc) begin
                            errors++;
                            $display("FAIL done dut%0d thr%0d: out %h at cyc %0d, required %h at cyc %0d",
                                     d, i, o, cyc, sb[hit].val, sb[hit].cyc);
                        end
                        sb.delete(hit);
                    end
                    if (ops_left[i] > 0) begin
                        ops_left[i]--;
                        drop[i] = ops_left[i] == 0;
                    end
                end else if (o !== '0) begin
                    errors++;
                    $display("FAIL idle_out dut%0d thr%0d: out %h at cyc %0d, required 0", d, i, o, cyc);
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (drop[i]) thr_sel[2*i +: 2] = S_NONE;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                thr_sel[2*i +: 2]      = 2'($urandom);
                thr_ctrl[i*W +: W]     = $urandom;
                thr_in[2*i*W +: W]     = $urandom;
                thr_in[(2*i+1)*W +: W] = $urandom;
            end
            #3;
            for (int d = 0; d < ND; d++) begin
                checks++;
                if ({done_w[d], out_w[d], alu_ctrl_w[d], alu_in_w[d], mem_ctrl_w[d], mem_in_w[d]} !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs dut%0d: done %b out %h alu_ctrl %h alu_in %h mem_ctrl %h mem_in %h, required all 0",
                             d, done_w[d], out_w[d], alu_ctrl_w[d], alu_in_w[d], mem_ctrl_w[d], mem_in_w[d]);
                end
            end
            @(posedge clk);
        end
        thr_sel = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({done_w[d], alu_ctrl_w[d], alu_in_w[d], mem_ctrl_w[d], mem_in_w[d]} !== '0) begin
                errors++;
                $display("FAIL idle_after_release dut%0d: done %b alu_ctrl %h mem_ctrl %h, required 0",
                         d, done_w[d], alu_ctrl_w[d], mem_ctrl_w[d]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_round_robin();
        int base;
        do_reset();
        base = cyc;
        for (int i = 0; i < N; i++) set_thr(i, S_ALU, i, 16 * i + 1, 100 + i, (i == 0) ? 2 : 1);
        for (int k = 0; k < 5; k++) push_exp(k % N, alu_f(k % N, 16 * (k % N) + 1, 100 + (k % N)), base + k);
        run(0, 7);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL alu_rr_missing: %0d dones outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_alu_mem_parallel();
        int base;
        do_reset();
        base = cyc;
        set_thr(2, S_MEM, 1, 32'h10, 0, 1);
        set_thr(1, S_ALU, 7, 5, 9, 1);
        push_exp(1, alu_f(7, 5, 9), base);
        push_exp(2, mem_f(1, 32'h10, 0), base + 1);
        run(0, 4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL parallel_missing: %0d dones outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_rr_wrap();
        int base;
        do_reset();
        base = cyc;
        set_thr(2, S_MEM, 2, 32'h20, 1, 1);
        push_exp(2, mem_f(2, 32'h20, 1), base + 2);
        run(1, 2);
        // New requests arrive in the cycle thread 2 completes; rr_ptr is then 3.
        set_thr(3, S_MEM, 3, 32'h30, 2, 1);
        set_thr(0, S_MEM, 4, 32'h40, 3, 1);
        set_thr(1, S_MEM, 5, 32'h50, 4, 1);
        push_exp(3, mem_f(3, 32'h30, 2), base + 5);
        push_exp(0, mem_f(4, 32'h40, 3), base + 8);
        push_exp(1, mem_f(5, 32'h50, 4), base + 11);
        run(1, 12);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_missing: %0d dones outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_busy();
        int base;
        do_reset();
        set_thr(1, S_MEM, 6, 32'h60, 5, 1);
        run(2, 2);
        rst = 1'b0;
        #1;
        checks++;
        if ({done_w[2], mem_ctrl_w[2], mem_in_w[2]} !== '0) begin
            errors++;
            $display("FAIL busy_reset_outputs: done %b mem_ctrl %h mem_in %h, required 0",
                     done_w[2], mem_ctrl_w[2], mem_in_w[2]);
        end
        set_thr(3, S_MEM, 7, 32'h70, 6, 1);
        run(2, 2);
        rst  = 1'b1;
        base = cyc;
        // rr_ptr back at 0 means thread 1 wins over thread 3.
        push_exp(1, mem_f(6, 32'h60, 5), base + 3);
        push_exp(3, mem_f(7, 32'h70, 6), base + 7);
        run(2, 9);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL busy_reset_missing: %0d dones outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_owner_drop();
        int base;
        do_reset();
        base = cyc;
        set_thr(0, S_MEM, 8, 32'h80, 7, 0);
        set_thr(2, S_MEM, 9, 32'h90, 8, 1);
        push_exp(0, mem_f(8, 32'h80, 7), base + 2);
        push_exp(2, mem_f(9, 32'h90, 8), base + 5);
        run(1, 1);
        thr_sel[1:0] = S_NONE;
        run(1, 6);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL owner_drop_missing: %0d dones outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu_round_robin();
        test_alu_mem_parallel();
        test_rr_wrap();
        test_reset_mid_busy();
        test_owner_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
